// File: rtl/gam_edge_age_sequencer.sv
// Purpose: runs one GAM topology update (link w/s, age the winner's row, prune stale edges, mirror every write).
// Latency: 2 link cycles + 1/2/3 per skipped/absent/present column + 1 DONE cycle; illegal requests go straight to DONE.
// Backpressure: req_ready is high only in IDLE; requests arriving while busy are ignored.
module gam_edge_age_sequencer #(
    parameter int NODE_COUNT  = 10,
    parameter int CLASS_COUNT = 4,
    parameter int AGE_MAX     = 2,
    parameter int AGE_W       = 8,
    localparam int NW = $clog2(NODE_COUNT + 1),
    localparam int CW = $clog2(CLASS_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CW-1:0]    req_class,
    input  logic [NW-1:0]    req_winner,
    input  logic [NW-1:0]    req_second,
    output logic             conn_rd_en,
    output logic [CW-1:0]    conn_rd_class,
    output logic [NW-1:0]    conn_rd_row,
    output logic [NW-1:0]    conn_rd_col,
    input  logic             conn_rd_presence,
    input  logic [AGE_W-1:0] conn_rd_age,
    output logic             conn_wr_en,
    output logic [CW-1:0]    conn_wr_class,
    output logic [NW-1:0]    conn_wr_row,
    output logic [NW-1:0]    conn_wr_col,
    output logic             conn_wr_presence,
    output logic [AGE_W-1:0] conn_wr_age,
    output logic             done,
    output logic             err,
    output logic [NW-1:0]    deleted_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LINK_A, S_LINK_B, S_READ, S_CHECK, S_MIRROR, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cls_q;
    logic [NW-1:0]     w_q, s_q, j_q;
    logic              err_q;
    logic              mir_pres_q;
    logic [AGE_W-1:0]  mir_age_q;
    logic [NW-1:0]     del_cnt_q;

    logic              req_legal;
    logic              skip_col, last_col, advance;
    logic [AGE_W-1:0]  age_inc;
    logic              expire;

    assign req_legal = (req_class != '0) && (req_class <= CW'(CLASS_COUNT)) &&
                       (req_winner != '0) && (req_winner <= NW'(NODE_COUNT)) &&
                       (req_second != '0) && (req_second <= NW'(NODE_COUNT)) &&
                       (req_winner != req_second);

    assign skip_col = (j_q == w_q) || (j_q == s_q);
    assign last_col = (j_q == NW'(NODE_COUNT));
    assign advance  = ((state_q == S_READ) && skip_col) ||
                      ((state_q == S_CHECK) && !conn_rd_presence) ||
                      (state_q == S_MIRROR);

    // All-ones age saturates instead of wrapping back to a fresh edge.
    assign age_inc = (&conn_rd_age) ? conn_rd_age : conn_rd_age + AGE_W'(1);
    assign expire  = ({1'b0, age_inc} > (AGE_W + 1)'(AGE_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cls_q      <= '0;
            w_q        <= '0;
            s_q        <= '0;
            j_q        <= '0;
            err_q      <= 1'b0;
            mir_pres_q <= 1'b0;
            mir_age_q  <= '0;
            del_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req_valid) begin
                cls_q     <= req_class;
                w_q       <= req_winner;
                s_q       <= req_second;
                err_q     <= !req_legal;
                del_cnt_q <= '0;
            end
            if (state_q == S_LINK_B) begin
                j_q <= NW'(1);
            end else if (advance) begin
                j_q <= j_q + NW'(1);
            end
            if (state_q == S_CHECK && conn_rd_presence) begin
                mir_pres_q <= !expire;
                mir_age_q  <= expire ? '0 : age_inc;
                if (expire) begin
                    del_cnt_q <= del_cnt_q + NW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid) state_d = req_legal ? S_LINK_A : S_DONE;
            S_LINK_A: state_d = S_LINK_B;
            S_LINK_B: state_d = S_READ;
            S_READ: begin
                if (!skip_col)     state_d = S_CHECK;
                else if (last_col) state_d = S_DONE;
            end
            S_CHECK: begin
                if (conn_rd_presence) state_d = S_MIRROR;
                else                  state_d = last_col ? S_DONE : S_READ;
            end
            S_MIRROR: state_d = last_col ? S_DONE : S_READ;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready        = (state_q == S_IDLE);
        conn_rd_en       = 1'b0;
        conn_rd_class    = '0;
        conn_rd_row      = '0;
        conn_rd_col      = '0;
        conn_wr_en       = 1'b0;
        conn_wr_class    = '0;
        conn_wr_row      = '0;
        conn_wr_col      = '0;
        conn_wr_presence = 1'b0;
        conn_wr_age      = '0;
        done             = 1'b0;
        err              = 1'b0;
        deleted_count    = del_cnt_q;
        case (state_q)
            S_LINK_A: begin
                conn_wr_en       = 1'b1;
                conn_wr_class    = cls_q;
                conn_wr_row      = w_q;
                conn_wr_col      = s_q;
                conn_wr_presence = 1'b1;
            end
            S_LINK_B: begin
                conn_wr_en       = 1'b1;
                conn_wr_class    = cls_q;
                conn_wr_row      = s_q;
                conn_wr_col      = w_q;
                conn_wr_presence = 1'b1;
            end
            S_READ: begin
                if (!skip_col) begin
                    conn_rd_en    = 1'b1;
                    conn_rd_class = cls_q;
                    conn_rd_row   = w_q;
                    conn_rd_col   = j_q;
                end
            end
            S_CHECK: begin
                if (conn_rd_presence) begin
                    conn_wr_en       = 1'b1;
                    conn_wr_class    = cls_q;
                    conn_wr_row      = w_q;
                    conn_wr_col      = j_q;
                    conn_wr_presence = !expire;
                    conn_wr_age      = expire ? '0 : age_inc;
                end
            end
            S_MIRROR: begin
                conn_wr_en       = 1'b1;
                conn_wr_class    = cls_q;
                conn_wr_row      = j_q;
                conn_wr_col      = w_q;
                conn_wr_presence = mir_pres_q;
                conn_wr_age      = mir_age_q;
            end
            S_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gam_edge_age_sequencer.sv
// Directed bench for gam_edge_age_sequencer: a default instance plus one with AGE_MAX=255 for saturation.
// Each instance talks to its own behavioural connection memory.
module tb_gam_edge_age_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic       req_valid = 1'b0;
    logic       use_sat = 1'b0;
    logic [2:0] req_class = '0;
    logic [3:0] req_winner = '0, req_second = '0;
    logic       rv_main, rv_sat;
    assign rv_main = req_valid && !use_sat;
    assign rv_sat  = req_valid && use_sat;

    // default instance
    logic       req_ready, rd_en, wr_en, wr_pres, done, err;
    logic [2:0] rd_class, wr_class;
    logic [3:0] rd_row, rd_col, wr_row, wr_col, deleted;
    logic [7:0] wr_age;
    logic       rd_p = 1'b0;
    logic [7:0] rd_a = '0;

    // saturation instance
    logic       s_req_ready, s_rd_en, s_wr_en, s_wr_pres, s_done, s_err;
    logic [2:0] s_rd_class, s_wr_class;
    logic [3:0] s_rd_row, s_rd_col, s_wr_row, s_wr_col, s_deleted;
    logic [7:0] s_wr_age;
    logic       s_rd_p = 1'b0;
    logic [7:0] s_rd_a = '0;

    gam_edge_age_sequencer u_dut (
        .clk(clk), .rst(rst),
        .req_valid(rv_main), .req_ready(req_ready),
        .req_class(req_class), .req_winner(req_winner), .req_second(req_second),
        .conn_rd_en(rd_en), .conn_rd_class(rd_class), .conn_rd_row(rd_row), .conn_rd_col(rd_col),
        .conn_rd_presence(rd_p), .conn_rd_age(rd_a),
        .conn_wr_en(wr_en), .conn_wr_class(wr_class), .conn_wr_row(wr_row), .conn_wr_col(wr_col),
        .conn_wr_presence(wr_pres), .conn_wr_age(wr_age),
        .done(done), .err(err), .deleted_count(deleted)
    );

    gam_edge_age_sequencer #(.AGE_MAX(255), .AGE_W(8)) u_sat (
        .clk(clk), .rst(rst),
        .req_valid(rv_sat), .req_ready(s_req_ready),
        .req_class(req_class), .req_winner(req_winner), .req_second(req_second),
        .conn_rd_en(s_rd_en), .conn_rd_class(s_rd_class), .conn_rd_row(s_rd_row), .conn_rd_col(s_rd_col),
        .conn_rd_presence(s_rd_p), .conn_rd_age(s_rd_a),
        .conn_wr_en(s_wr_en), .conn_wr_class(s_wr_class), .conn_wr_row(s_wr_row), .conn_wr_col(s_wr_col),
        .conn_wr_presence(s_wr_pres), .conn_wr_age(s_wr_age),
        .done(s_done), .err(s_err), .deleted_count(s_deleted)
    );

    logic       mem_p  [8][16][16];
    logic [7:0] mem_a  [8][16][16];
    logic       mem2_p [8][16][16];
    logic [7:0] mem2_a [8][16][16];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_p <= mem_p[rd_class][rd_row][rd_col];
            rd_a <= mem_a[rd_class][rd_row][rd_col];
        end
        if (wr_en) begin
            mem_p[wr_class][wr_row][wr_col] = wr_pres;
            mem_a[wr_class][wr_row][wr_col] = wr_age;
        end
    end

    always @(posedge clk) begin
        if (s_rd_en) begin
            s_rd_p <= mem2_p[s_rd_class][s_rd_row][s_rd_col];
            s_rd_a <= mem2_a[s_rd_class][s_rd_row][s_rd_col];
        end
        if (s_wr_en) begin
            mem2_p[s_wr_class][s_wr_row][s_wr_col] = s_wr_pres;
            mem2_a[s_wr_class][s_wr_row][s_wr_col] = s_wr_age;
        end
    end

    logic       m_wr_en, m_rd_en, m_done, m_err, m_req_ready;
    logic [3:0] m_rd_col, m_deleted;
    assign m_wr_en     = use_sat ? s_wr_en     : wr_en;
    assign m_rd_en     = use_sat ? s_rd_en     : rd_en;
    assign m_rd_col    = use_sat ? s_rd_col    : rd_col;
    assign m_done      = use_sat ? s_done      : done;
    assign m_err       = use_sat ? s_err       : err;
    assign m_deleted   = use_sat ? s_deleted   : deleted;
    assign m_req_ready = use_sat ? s_req_ready : req_ready;

    int n_checks = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int         t0, wr_cnt, rd_cnt, wr1, wr2, done_cyc;
    logic       got_done, err_s, skip_rd, ready1;
    logic [3:0] del_s;

    // Issue one request and observe the update until done (bounded).
    task automatic run_req(input logic [2:0] c, input logic [3:0] w, input logic [3:0] s);
        @(negedge clk);
        req_class = c; req_winner = w; req_second = s; req_valid = 1'b1;
        t0 = cyc; wr_cnt = 0; rd_cnt = 0; wr1 = -1; wr2 = -1; done_cyc = -1;
        got_done = 1'b0; err_s = 1'b0; skip_rd = 1'b0; del_s = '0;
        @(negedge clk);
        req_valid = 1'b0;
        ready1 = m_req_ready;
        for (int k = 0; k < 60 && !got_done; k++) begin
            if (m_wr_en) begin
                wr_cnt++;
                if (wr_cnt == 1) wr1 = cyc - t0;
                else if (wr_cnt == 2) wr2 = cyc - t0;
            end
            if (m_rd_en) begin
                rd_cnt++;
                if (m_rd_col == w || m_rd_col == s) skip_rd = 1'b1;
            end
            if (m_done) begin
                got_done = 1'b1;
                done_cyc = cyc - t0;
                err_s = m_err;
                del_s = m_deleted;
            end else begin
                @(negedge clk);
            end
        end
        if (!got_done) check_val("done_timeout", 32'd0, 32'd1);
    endtask

    logic hit;

    initial begin
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 16; r++)
                for (int q = 0; q < 16; q++) begin
                    mem_p[c][r][q] = 1'b0;  mem_a[c][r][q] = '0;
                    mem2_p[c][r][q] = 1'b0; mem2_a[c][r][q] = '0;
                end

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_ready", req_ready, 1);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_deleted", deleted, 0);
        check_val("rst_rd_en", rd_en, 0);
        check_val("rst_wr_en", wr_en, 0);
        check_val("rst_wr_row", wr_row, 0);
        check_val("rst_wr_age", wr_age, 0);
        rst = 1'b0;

        // empty class 1, w=3 s=5
        run_req(3'd1, 4'd3, 4'd5);
        check_val("t1_wr1_cyc", wr1, 1);
        check_val("t1_wr2_cyc", wr2, 2);
        check_val("t1_busy_ready", ready1, 0);
        check_val("t1_rd_cnt", rd_cnt, 8);
        check_val("t1_wr_cnt", wr_cnt, 2);
        check_val("t1_done_cyc", done_cyc, 21);
        check_val("t1_err", err_s, 0);
        check_val("t1_deleted", del_s, 0);
        check_val("t1_p35", mem_p[1][3][5], 1);
        check_val("t1_a35", mem_a[1][3][5], 0);
        check_val("t1_p53", mem_p[1][5][3], 1);
        check_val("t1_skip_rd", skip_rd, 0);

        // ageing and deletion in class 2
        mem_p[2][3][7] = 1'b1; mem_a[2][3][7] = 8'd1;
        mem_p[2][7][3] = 1'b1; mem_a[2][7][3] = 8'd1;
        mem_p[2][3][8] = 1'b1; mem_a[2][3][8] = 8'd2;
        mem_p[2][8][3] = 1'b1; mem_a[2][8][3] = 8'd2;
        run_req(3'd2, 4'd3, 4'd5);
        check_val("t2_p37", mem_p[2][3][7], 1);
        check_val("t2_a37", mem_a[2][3][7], 2);
        check_val("t2_p73", mem_p[2][7][3], 1);
        check_val("t2_a73", mem_a[2][7][3], 2);
        check_val("t2_p38", mem_p[2][3][8], 0);
        check_val("t2_p83", mem_p[2][8][3], 0);
        check_val("t2_a83", mem_a[2][8][3], 0);
        check_val("t2_deleted", del_s, 1);
        check_val("t2_wr_cnt", wr_cnt, 6);
        check_val("t2_done_cyc", done_cyc, 23);

        // pre-existing (w,s) edge refreshed, never aged or read
        mem_p[3][3][5] = 1'b1; mem_a[3][3][5] = 8'd2;
        mem_p[3][5][3] = 1'b1; mem_a[3][5][3] = 8'd2;
        run_req(3'd3, 4'd3, 4'd5);
        check_val("t3_p35", mem_p[3][3][5], 1);
        check_val("t3_a35", mem_a[3][3][5], 0);
        check_val("t3_a53", mem_a[3][5][3], 0);
        check_val("t3_deleted", del_s, 0);
        check_val("t3_skip_rd", skip_rd, 0);
        check_val("t3_rd_cnt", rd_cnt, 8);

        // illegal requests
        run_req(3'd1, 4'd4, 4'd4);
        check_val("t4a_err", err_s, 1);
        check_val("t4a_wr_cnt", wr_cnt, 0);
        run_req(3'd1, 4'd0, 4'd5);
        check_val("t4b_err", err_s, 1);
        check_val("t4b_wr_cnt", wr_cnt, 0);
        run_req(3'd5, 4'd3, 4'd5);
        check_val("t4c_err", err_s, 1);
        check_val("t4c_wr_cnt", wr_cnt, 0);

        // reset during CHECK of column 6
        mem_p[4][3][6] = 1'b1; mem_a[4][3][6] = 8'd0;
        mem_p[4][6][3] = 1'b1; mem_a[4][6][3] = 8'd0;
        @(negedge clk);
        req_class = 3'd4; req_winner = 4'd3; req_second = 4'd5; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            if (rd_en && rd_col == 4'd6) hit = 1'b1;
            else @(negedge clk);
        end
        check_val("t5_reach_j6", hit, 1);
        @(negedge clk);
        check_val("t5_check_wr", wr_en, 1);
        rst = 1'b1;
        @(negedge clk);
        check_val("t5_ready", req_ready, 1);
        check_val("t5_wr_en", wr_en, 0);
        check_val("t5_deleted", deleted, 0);
        check_val("t5_a36", mem_a[4][3][6], 1);
        check_val("t5_a63", mem_a[4][6][3], 0);
        rst = 1'b0;
        run_req(3'd4, 4'd2, 4'd1);
        check_val("t5_new_err", err_s, 0);
        check_val("t5_new_done_cyc", done_cyc, 21);
        check_val("t5_new_wr_cnt", wr_cnt, 2);

        // saturating age with AGE_MAX=255
        use_sat = 1'b1;
        mem2_p[1][3][9] = 1'b1; mem2_a[1][3][9] = 8'd255;
        mem2_p[1][9][3] = 1'b1; mem2_a[1][9][3] = 8'd255;
        run_req(3'd1, 4'd3, 4'd5);
        check_val("t6_p39", mem2_p[1][3][9], 1);
        check_val("t6_a39", mem2_a[1][3][9], 255);
        check_val("t6_a93", mem2_a[1][9][3], 255);
        check_val("t6_deleted", del_s, 0);
        use_sat = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
